// File: rtl/obstacle_logic.sv
// Game-state and collision controller for the Flappy VGA game.
// Three-state FSM (Initial/Check/Lose) with one-hot state register driving the outputs directly.
module obstacle_logic #(
  parameter int BIRD_W   = 20,
  parameter int BIRD_H   = 20,
  parameter int PIPE_W   = 40,
  parameter int GAP_H    = 80,
  parameter int SCREEN_H = 480
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic [9:0] X_Edge,
  input  logic [9:0] Y_Edge,
  input  logic [9:0] Bird_X,
  input  logic [9:0] Bird_Y,
  output logic       Q_Initial,
  output logic       Q_Check,
  output logic       Q_Lose
);

  localparam logic [2:0] ST_INITIAL = 3'b001;
  localparam logic [2:0] ST_CHECK   = 3'b010;
  localparam logic [2:0] ST_LOSE    = 3'b100;

  localparam logic signed [11:0] BIRD_W_S   = 12'(BIRD_W);
  localparam logic signed [11:0] BIRD_H_S   = 12'(BIRD_H);
  localparam logic signed [11:0] PIPE_W_S   = 12'(PIPE_W);
  localparam logic signed [11:0] GAP_H_S    = 12'(GAP_H);
  localparam logic signed [11:0] SCREEN_H_S = 12'(SCREEN_H);

  logic [2:0]         state_r;
  logic [2:0]         state_nxt_s;
  logic signed [11:0] x_edge_s;
  logic signed [11:0] y_edge_s;
  logic signed [11:0] bird_x_s;
  logic signed [11:0] bird_y_s;
  logic               hx_s;
  logic               outgap_s;
  logic               bound_s;
  logic               hit_s;

  // Pipe coordinates are unsigned screen positions; the bird may sit partly off-screen, hence signed.
  assign x_edge_s = $signed({2'b00, X_Edge});
  assign y_edge_s = $signed({2'b00, Y_Edge});
  assign bird_x_s = $signed({{2{Bird_X[9]}}, Bird_X});
  assign bird_y_s = $signed({{2{Bird_Y[9]}}, Bird_Y});

  // Strict comparisons: touching an edge is not a collision.
  assign hx_s     = ((bird_x_s + BIRD_W_S) > x_edge_s) && (bird_x_s < (x_edge_s + PIPE_W_S));
  assign outgap_s = (bird_y_s < y_edge_s) || ((bird_y_s + BIRD_H_S) > (y_edge_s + GAP_H_S));
  assign bound_s  = (bird_y_s < 12'sd0) || ((bird_y_s + BIRD_H_S) > SCREEN_H_S);
  assign hit_s    = (hx_s && outgap_s) || bound_s;

  // Next-state selection; each state honours only its own trigger input.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_INITIAL: begin
        if (Start) state_nxt_s = ST_CHECK;
        else       state_nxt_s = ST_INITIAL;
      end
      ST_CHECK: begin
        if (hit_s) state_nxt_s = ST_LOSE;
        else       state_nxt_s = ST_CHECK;
      end
      ST_LOSE: begin
        if (Ack)   state_nxt_s = ST_INITIAL;
        else       state_nxt_s = ST_LOSE;
      end
      default:     state_nxt_s = ST_INITIAL;
    endcase
  end

  // State register with synchronous reset; illegal encodings recover via the default arm.
  always_ff @(posedge Clk) begin
    if (reset) state_r <= ST_INITIAL;
    else       state_r <= state_nxt_s;
  end

  assign Q_Initial = state_r[0];
  assign Q_Check   = state_r[1];
  assign Q_Lose    = state_r[2];

endmodule

// File: tb/tb_obstacle_logic.sv
// Directed-vector bench for obstacle_logic; expected states are hand-derived from the collision rules.
module tb_obstacle_logic;

  localparam logic [2:0] EXP_I = 3'b100;
  localparam logic [2:0] EXP_C = 3'b010;
  localparam logic [2:0] EXP_L = 3'b001;

  logic       Clk = 1'b0;
  logic       reset;
  logic       Start;
  logic       Ack;
  logic [9:0] X_Edge;
  logic [9:0] Y_Edge;
  logic [9:0] Bird_X;
  logic [9:0] Bird_Y;
  logic       Q_Initial;
  logic       Q_Check;
  logic       Q_Lose;

  int n_vec = 0;
  int n_bad = 0;

  obstacle_logic dut (
    .Clk       (Clk),
    .reset     (reset),
    .Start     (Start),
    .Ack       (Ack),
    .X_Edge    (X_Edge),
    .Y_Edge    (Y_Edge),
    .Bird_X    (Bird_X),
    .Bird_Y    (Bird_Y),
    .Q_Initial (Q_Initial),
    .Q_Check   (Q_Check),
    .Q_Lose    (Q_Lose)
  );

  always #5 Clk = ~Clk;

  task automatic check_state(input string tag, input logic [2:0] got, input logic [2:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {I,C,L}=%b expected %b (X_Edge=%0d Bird_Y=%0d)", tag, got, exp, X_Edge, Bird_Y);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] exp);
    tick();
    check_state(tag, {Q_Initial, Q_Check, Q_Lose}, exp);
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; Ack = 1'b0;
    X_Edge = 10'd350; Y_Edge = 10'd270; Bird_X = 10'd320; Bird_Y = 10'd240;
    repeat (4) tick();
    step("reset", EXP_I);
    reset = 1'b0;

    // Initial ignores Ack and collisions
    Ack = 1'b1; step("ack_in_init", EXP_I); Ack = 1'b0;
    X_Edge = 10'd339; step("hit_in_init", EXP_I); X_Edge = 10'd350;

    Start = 1'b1; step("start", EXP_C); Start = 1'b0;
    Ack = 1'b1; step("ack_in_check", EXP_C); Ack = 1'b0;
    Start = 1'b1; step("start_in_check", EXP_C); Start = 1'b0;

    // Bird above gap: first overlap at X_Edge=339
    for (int x = 349; x >= 339; x--) begin
      X_Edge = 10'(x);
      step("x_sweep", (x == 339) ? EXP_L : EXP_C);
    end
    X_Edge = 10'd330; step("lose_hold", EXP_L);
    Start = 1'b1; step("start_in_lose", EXP_L); Start = 1'b0;
    Ack = 1'b1; step("ack_lose", EXP_I); Ack = 1'b0;

    // Bird inside the gap: pipe passes without a loss
    Bird_Y = 10'd290; X_Edge = 10'd350;
    Start = 1'b1; step("start_gap", EXP_C); Start = 1'b0;
    for (int x = 349; x >= 270; x--) begin
      X_Edge = 10'(x);
      step("gap_sweep", EXP_C);
    end

    // Gap edge contact with full horizontal overlap
    X_Edge = 10'd310;
    Bird_Y = 10'd270; step("gap_top_touch", EXP_C);
    Bird_Y = 10'd330; step("gap_bot_touch", EXP_C);
    Bird_Y = 10'd331; step("gap_bot_over", EXP_L);
    Ack = 1'b1; Bird_Y = 10'd240; X_Edge = 10'd350; step("ack2", EXP_I); Ack = 1'b0;

    // Pipe right edge touching bird left edge
    Start = 1'b1; X_Edge = 10'd280; step("start3", EXP_C); Start = 1'b0;
    step("right_touch", EXP_C);
    X_Edge = 10'd281; step("right_overlap", EXP_L);
    Ack = 1'b1; X_Edge = 10'd350; step("ack3", EXP_I); Ack = 1'b0;

    // Screen bounds, pipe far away
    Start = 1'b1; step("start4", EXP_C); Start = 1'b0;
    X_Edge = 10'd1000;
    Bird_Y = 10'd460; step("bottom_ok", EXP_C);
    Bird_Y = 10'd465; step("bottom_hit", EXP_L);
    Ack = 1'b1; Bird_Y = 10'd240; step("ack4", EXP_I); Ack = 1'b0;
    Start = 1'b1; step("start5", EXP_C); Start = 1'b0;
    Bird_Y = 10'd0; step("top_ok", EXP_C);
    Bird_Y = 10'h3FB; step("top_hit", EXP_L);
    Ack = 1'b1; Bird_Y = 10'd240; step("ack5", EXP_I); Ack = 1'b0;

    // Ack coinciding with a hit in CHECK
    X_Edge = 10'd350;
    Start = 1'b1; step("start6", EXP_C); Start = 1'b0;
    Ack = 1'b1; X_Edge = 10'd339; step("ack_with_hit", EXP_L);
    step("ack_after_hit", EXP_I); Ack = 1'b0; X_Edge = 10'd350;

    // Wrapped pipe and a bird partly off the left edge
    Start = 1'b1; step("start7", EXP_C); Start = 1'b0;
    X_Edge = 10'd1023; step("wrap", EXP_C);
    Bird_X = 10'h3F6; step("wrap_neg_bird", EXP_C);
    X_Edge = 10'd0; step("neg_bird_hit", EXP_L);

    // Reset from LOSE and mid-game
    reset = 1'b1; step("reset_lose", EXP_I); reset = 1'b0;
    Bird_X = 10'd320; X_Edge = 10'd350;
    Start = 1'b1; step("start8", EXP_C); Start = 1'b0;
    reset = 1'b1; X_Edge = 10'd339; step("reset_mid", EXP_I); reset = 1'b0;
    step("post_reset", EXP_I);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
